// File: rtl/bram_arbiter.sv
// N-to-1 BRAM port arbiter: per-port holding slot, round-robin grant, read-return routing.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rr pointer).
module bram_arbiter #(
    parameter int NB_PORTS   = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 512,
    parameter int RD_LATENCY = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0]  req_wr_data,
    input  logic [NB_PORTS-1:0]                  req_rd_en,
    input  logic [NB_PORTS-1:0]                  req_wr_en,
    output logic [NB_PORTS-1:0]                  req_ready,
    output logic [NB_PORTS-1:0][DATA_WIDTH-1:0]  rsp_rd_data,
    output logic [NB_PORTS-1:0]                  rsp_rd_valid,
    output logic [ADDR_WIDTH-1:0]                bram_addr,
    output logic [DATA_WIDTH-1:0]                bram_wr_data,
    output logic                                 bram_rd_en,
    output logic                                 bram_wr_en,
    input  logic [DATA_WIDTH-1:0]                bram_rd_data
);

    localparam int IDW = $clog2(NB_PORTS);

    logic [NB_PORTS-1:0]                 slot_valid_q, slot_valid_d;
    logic [NB_PORTS-1:0][ADDR_WIDTH-1:0] slot_addr_q;
    logic [NB_PORTS-1:0][DATA_WIDTH-1:0] slot_data_q;
    logic [NB_PORTS-1:0]                 slot_rd_q;
    logic [NB_PORTS-1:0]                 slot_wr_q;

    logic [NB_PORTS-1:0] grant;
    logic [NB_PORTS-1:0] accept;
    logic                gnt_vld;
    logic [IDW-1:0]      gnt_idx;

    logic [ADDR_WIDTH-1:0] bram_addr_q;
    logic [DATA_WIDTH-1:0] bram_wr_data_q;
    logic                  bram_rd_en_q;
    logic                  bram_wr_en_q;

    // Port-ID pipeline; stage RD_LATENCY lines up with bram_rd_data.
    logic [RD_LATENCY:0]          pv_q;
    logic [RD_LATENCY:0][IDW-1:0] pid_q;

    logic [NB_PORTS-1:0]                 rsp_valid_q;
    logic [NB_PORTS-1:0][DATA_WIDTH-1:0] rsp_data_q;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = NB_PORTS - 1; i >= 0; i--) begin
            if (slot_valid_q[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW:0]   rr_idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        for (int k = 0; k < NB_PORTS; k++) begin
            rr_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (rr_idx >= (IDW+1)'(NB_PORTS))
                rr_idx = rr_idx - (IDW+1)'(NB_PORTS);
            if (!gnt_vld && slot_valid_q[rr_idx[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_idx[IDW-1:0];
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld)
            rr_ptr_d = (int'(gnt_idx) == NB_PORTS - 1) ? '0 : gnt_idx + IDW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        grant = '0;
        if (gnt_vld) grant[gnt_idx] = 1'b1;
    end

    // A granted slot drains this edge, so it can take a new request.
    assign req_ready    = ~slot_valid_q | grant;
    assign accept       = (req_rd_en | req_wr_en) & req_ready;
    assign slot_valid_d = (slot_valid_q & ~grant) | accept;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_PORTS; i++) begin
            if (accept[i]) begin
                slot_addr_q[i] <= req_addr[i];
                slot_data_q[i] <= req_wr_data[i];
                slot_rd_q[i]   <= req_rd_en[i];
                slot_wr_q[i]   <= req_wr_en[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q   <= '0;
            bram_addr_q    <= '0;
            bram_wr_data_q <= '0;
            bram_rd_en_q   <= 1'b0;
            bram_wr_en_q   <= 1'b0;
            pv_q           <= '0;
            pid_q          <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            if (gnt_vld) begin
                bram_addr_q    <= slot_addr_q[gnt_idx];
                bram_wr_data_q <= slot_data_q[gnt_idx];
            end
            bram_rd_en_q <= gnt_vld & slot_rd_q[gnt_idx];
            bram_wr_en_q <= gnt_vld & slot_wr_q[gnt_idx];
            pv_q  <= {pv_q[RD_LATENCY-1:0], gnt_vld & slot_rd_q[gnt_idx]};
            pid_q <= {pid_q[RD_LATENCY-1:0], gnt_idx};
            rsp_valid_q <= '0;
            if (pv_q[RD_LATENCY]) begin
                rsp_valid_q[pid_q[RD_LATENCY]] <= 1'b1;
                rsp_data_q[pid_q[RD_LATENCY]]  <= bram_rd_data;
            end
        end
    end

    assign bram_addr    = bram_addr_q;
    assign bram_wr_data = bram_wr_data_q;
    assign bram_rd_en   = bram_rd_en_q;
    assign bram_wr_en   = bram_wr_en_q;
    assign rsp_rd_valid = rsp_valid_q;
    assign rsp_rd_data  = rsp_data_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a 2-cycle BRAM model.
// Fixed-priority scenario runs when BRAM_ARB_FIXED_PRIO_EN is defined.
module tb_bram_arbiter;

    localparam int NB = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    logic               clk;
    logic               rst_n;
    logic [NB-1:0][AW-1:0] req_addr;
    logic [NB-1:0][DW-1:0] req_wr_data;
    logic [NB-1:0]      req_rd_en;
    logic [NB-1:0]      req_wr_en;
    logic [NB-1:0]      req_ready;
    logic [NB-1:0][DW-1:0] rsp_rd_data;
    logic [NB-1:0]      rsp_rd_valid;
    logic [AW-1:0]      bram_addr;
    logic [DW-1:0]      bram_wr_data;
    logic               bram_rd_en;
    logic               bram_wr_en;
    logic [DW-1:0]      bram_rd_data;

    bram_arbiter #(
        .NB_PORTS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr(req_addr), .req_wr_data(req_wr_data),
        .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
        .req_ready(req_ready),
        .rsp_rd_data(rsp_rd_data), .rsp_rd_valid(rsp_rd_valid),
        .bram_addr(bram_addr), .bram_wr_data(bram_wr_data),
        .bram_rd_en(bram_rd_en), .bram_wr_en(bram_wr_en),
        .bram_rd_data(bram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {20'h0, a};
    endfunction

    // BRAM model: read-first, data valid two edges after rd_en is sampled
    logic [DW-1:0] mem [4096];
    bit            wv  [4096];
    logic [DW-1:0] s1, s2;
    always @(posedge clk) begin
        if (bram_wr_en) begin
            mem[bram_addr] <= bram_wr_data;
            wv[bram_addr]  <= 1'b1;
        end
        if (bram_rd_en) s1 <= wv[bram_addr] ? mem[bram_addr] : pat(bram_addr);
        s2 <= s1;
    end
    assign bram_rd_data = s2;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    op_t     opq [NB][$];
    exp_t    sb  [NB][$];
    exp_t    wsb [$];
    int      glog [$];
    logic [DW-1:0] ref_mem [4096];
    int      stalls [NB];
    int      cyc, n_chk, n_pass, n_rsp;
    bit      lat_chk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_ports();
        for (int p = 0; p < NB; p++) begin
            if (opq[p].size() > 0) begin
                req_rd_en[p]   = opq[p][0].rd;
                req_wr_en[p]   = opq[p][0].wr;
                req_addr[p]    = opq[p][0].addr;
                req_wr_data[p] = opq[p][0].data;
            end else begin
                req_rd_en[p] = 1'b0;
                req_wr_en[p] = 1'b0;
            end
        end
    endtask

    task automatic sample();
        op_t  o;
        exp_t e;
        for (int p = 0; p < NB; p++) begin
            if (rsp_rd_valid[p]) begin
                n_rsp++;
                if (sb[p].size() == 0) begin
                    check("unexp_rsp", 64'(p), 64'hFF);
                end else begin
                    e = sb[p].pop_front();
                    check("rsp_data", 64'(rsp_rd_data[p]), 64'(e.data));
                    if (e.due != 0) check("rsp_lat", 64'(cyc), 64'(e.due));
                end
            end
        end
        if (bram_wr_en) begin
            if (wsb.size() == 0) begin
                check("unexp_wr", 64'(bram_addr), 64'hFFFF);
            end else begin
                e = wsb.pop_front();
                check("wr_addr", 64'(bram_addr), 64'(e.addr));
                check("wr_data", 64'(bram_wr_data), 64'(e.data));
                if (e.due != 0) check("wr_lat", 64'(cyc), 64'(e.due));
            end
        end
        if (bram_rd_en || bram_wr_en) glog.push_back(int'(bram_addr[9:8]));
        // Accept happens at the coming edge, numbered cyc+1
        for (int p = 0; p < NB; p++) begin
            if ((req_rd_en[p] || req_wr_en[p]) && opq[p].size() > 0) begin
                if (req_ready[p]) begin
                    o = opq[p].pop_front();
                    if (o.wr) begin
                        ref_mem[o.addr] = o.data;
                        e.addr = o.addr; e.data = o.data;
                        e.due  = lat_chk ? cyc + 2 : 0;
                        wsb.push_back(e);
                    end
                    if (o.rd) begin
                        e.addr = o.addr; e.data = ref_mem[o.addr];
                        e.due  = lat_chk ? cyc + 5 : 0;
                        sb[p].push_back(e);
                    end
                end else begin
                    stalls[p]++;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        #1;
        drive_ports();
        @(negedge clk);
        sample();
    endtask

    function automatic bit busy();
        bit b = (wsb.size() != 0);
        for (int p = 0; p < NB; p++)
            if (opq[p].size() != 0 || sb[p].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic run_idle(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            cycle();
            n++;
        end
        check("drain", 64'(busy()), 64'h0);
        repeat (3) cycle();
    endtask

    task automatic push_rd(input int p, input logic [AW-1:0] a);
        op_t o;
        o.rd = 1'b1; o.wr = 1'b0; o.addr = a; o.data = '0;
        opq[p].push_back(o);
    endtask

    task automatic clear_all();
        for (int p = 0; p < NB; p++) begin
            opq[p].delete();
            sb[p].delete();
            stalls[p] = 0;
        end
        wsb.delete();
        req_rd_en = '0;
        req_wr_en = '0;
    endtask

    task automatic test_all_ports(input string tag);
        glog.delete();
        lat_chk = 1'b0;
        for (int p = 0; p < NB; p++) push_rd(p, AW'(p * 256 + 1));
        cycle();
        cycle(); check({tag, "_rdy0"}, 64'(req_ready), 64'h1);
        cycle(); check({tag, "_rdy1"}, 64'(req_ready), 64'h3);
        cycle(); check({tag, "_rdy2"}, 64'(req_ready), 64'h7);
        cycle(); check({tag, "_rdy3"}, 64'(req_ready), 64'hF);
        run_idle(40);
        check({tag, "_ngnt"}, 64'(glog.size()), 64'd4);
        for (int k = 0; k < 4 && k < glog.size(); k++)
            check({tag, "_gnt"}, 64'(glog[k]), 64'(k));
    endtask

    initial begin
        op_t o;
        int  bad, cnt;
        cyc = 0; n_chk = 0; n_pass = 0; n_rsp = 0; lat_chk = 1'b0;
        for (int a = 0; a < 4096; a++) ref_mem[a] = pat(AW'(a));
        rst_n = 1'b0;
        req_addr = '0; req_wr_data = '0;
        clear_all();
        repeat (2) @(negedge clk);
        check("rst_rd_en", 64'(bram_rd_en), 64'h0);
        check("rst_wr_en", 64'(bram_wr_en), 64'h0);
        check("rst_addr",  64'(bram_addr), 64'h0);
        check("rst_rsp_v", 64'(rsp_rd_valid), 64'h0);
        check("rst_ready", 64'(req_ready), 64'hF);
        #2 rst_n = 1'b1;

        // All four ports request together right after reset
        test_all_ports("t2");

        // Write then read back on port 0, exact latencies
        lat_chk = 1'b1;
        o.rd = 1'b0; o.wr = 1'b1; o.addr = 12'h010; o.data = 32'hAB;
        opq[0].push_back(o);
        push_rd(0, 12'h010);
        run_idle(40);

        // Port 2 streams 16 reads back-to-back
        lat_chk = 1'b1;
        stalls[2] = 0;
        for (int a = 0; a < 16; a++) push_rd(2, AW'(a));
        run_idle(60);
        check("t3_stall", 64'(stalls[2]), 64'h0);

`ifdef BRAM_ARB_FIXED_PRIO_EN
        // Port 0 starves port 1 until it stops
        glog.delete();
        lat_chk = 1'b0;
        for (int n = 0; n < 10; n++) push_rd(0, AW'(n));
        for (int n = 0; n < 3; n++)  push_rd(1, AW'(256 + n));
        run_idle(80);
        check("t6_ngnt", 64'(glog.size()), 64'd13);
        cnt = 0;
        for (int k = 0; k < 10 && k < glog.size(); k++) if (glog[k] == 0) cnt++;
        check("t6_p0first", 64'(cnt), 64'd10);
        if (glog.size() > 10) check("t6_p1next", 64'(glog[10]), 64'd1);
`else
        // Ports 1 and 3 contend continuously
        glog.delete();
        lat_chk = 1'b0;
        for (int n = 0; n < 8; n++) begin
            push_rd(1, AW'(256 + n));
            push_rd(3, AW'(768 + n));
        end
        run_idle(80);
        check("t4_ngnt", 64'(glog.size()), 64'd16);
        bad = 0; cnt = 0;
        for (int k = 0; k < glog.size(); k++) begin
            if (glog[k] == 1) cnt++;
            if (k > 0 && glog[k] == glog[k-1]) bad++;
        end
        check("t4_alt", 64'(bad), 64'h0);
        check("t4_p1cnt", 64'(cnt), 64'd8);
`endif

        // Reset with three reads in flight
        lat_chk = 1'b0;
        for (int n = 0; n < 3; n++) push_rd(0, AW'(32 + n));
        repeat (4) cycle();
        check("t5_pre_rd", 64'(bram_rd_en), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rd_en", 64'(bram_rd_en), 64'h0);
        check("t5_wr_en", 64'(bram_wr_en), 64'h0);
        check("t5_rsp_v", 64'(rsp_rd_valid), 64'h0);
        check("t5_rsp_d", 64'(rsp_rd_data[0]), 64'h0);
        clear_all();
        repeat (2) cycle();
        #2 rst_n = 1'b1;
        n_rsp = 0;
        repeat (8) cycle();
        check("t5_quiet", 64'(n_rsp), 64'h0);
        test_all_ports("t5");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
